// File: rtl/digit_pkg.sv
// Shared types and helpers for the digit ROI sequencer: FSM encodings, border RAM
// address mapping and the edge clamp used on every border value.
package digit_pkg;

    localparam int unsigned PIX_W     = 11;
    localparam int unsigned BORDER_W  = 12;
    localparam int unsigned LEAD_OFS  = 1;
    localparam int unsigned TRAIL_OFS = 2;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RD_ROW,
        ST_RD_COL,
        ST_EMIT
    } seq_state_e;

    typedef enum logic [1:0] {
        PH_IDLE,
        PH_LEAD,
        PH_TRAIL,
        PH_CAP
    } rd_phase_e;

    // Leading edges arrive pre-decremented and may have wrapped, so out-of-range means 0;
    // trailing edges saturate at the last valid pixel.
    function automatic logic [PIX_W-1:0] edge_clamp(input logic [BORDER_W-1:0] value,
                                                    input logic [PIX_W-1:0]    total,
                                                    input logic                is_lead);
        if (value < BORDER_W'(total)) begin
            return value[PIX_W-1:0];
        end
        return is_lead ? '0 : total - PIX_W'(1);
    endfunction

endpackage

// File: rtl/digit_roi_sequencer_reader.sv
// Reads one lead/trail border pair (addresses 2k+1, 2k+2) from a 1-cycle-latency RAM
// and pulses done_o in the cycle the trailing value is on data_i.
module border_pair_reader
    import digit_pkg::*;
#(
    parameter int unsigned W     = 12,
    parameter int unsigned IDX_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start_i,
    input  logic [IDX_W-1:0] idx_i,
    input  logic [W-1:0]     data_i,
    output logic [W-1:0]     addr_o,
    output logic [W-1:0]     lead_o,
    output logic [W-1:0]     trail_o,
    output logic             done_o
);

    rd_phase_e        phase_q, phase_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic [W-1:0]     lead_q, lead_d;
    logic [W-1:0]     trail_q, trail_d;
    logic [W-1:0]     base;

    always_comb begin
        phase_d = phase_q;
        idx_d   = idx_q;
        lead_d  = lead_q;
        trail_d = trail_q;
        done_o  = 1'b0;
        addr_o  = '0;
        base    = W'(idx_q) << 1;
        case (phase_q)
            PH_IDLE: begin
                if (start_i) begin
                    phase_d = PH_LEAD;
                    idx_d   = idx_i;
                end
            end
            PH_LEAD: begin
                addr_o  = base + W'(LEAD_OFS);
                phase_d = PH_TRAIL;
            end
            PH_TRAIL: begin
                addr_o  = base + W'(TRAIL_OFS);
                lead_d  = data_i;
                phase_d = PH_CAP;
            end
            PH_CAP: begin
                trail_d = data_i;
                done_o  = 1'b1;
                phase_d = PH_IDLE;
            end
            default: phase_d = PH_IDLE;
        endcase
        lead_o  = lead_q;
        // Pass the trailing value straight through on done so the consumer can use it
        // in the same cycle.
        trail_o = trail_d;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            phase_q <= PH_IDLE;
            idx_q   <= '0;
            lead_q  <= '0;
            trail_q <= '0;
        end else begin
            phase_q <= phase_d;
            idx_q   <= idx_d;
            lead_q  <= lead_d;
            trail_q <= trail_d;
        end
    end

endmodule

// File: rtl/digit_roi_sequencer.sv
// Walks the row/column border RAMs after projection completes and emits one clamped
// bounding box per (row band, column band) pair over a valid/ready handshake.
module digit_roi_sequencer
    import digit_pkg::*;
#(
    parameter int unsigned NUM_ROW = 1,
    parameter int unsigned NUM_COL = 4,
    parameter int unsigned DEPBIT  = BORDER_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              project_done_flag,
    input  logic [3:0]        num_row,
    input  logic [3:0]        num_col,
    input  logic [10:0]       h_total_pexel,
    input  logic [10:0]       v_total_pexel,
    output logic [DEPBIT-1:0] row_border_addr_rd,
    input  logic [DEPBIT-1:0] row_border_data_rd,
    output logic [DEPBIT-1:0] col_border_addr_rd,
    input  logic [DEPBIT-1:0] col_border_data_rd,
    output logic              roi_valid,
    input  logic              roi_ready,
    output logic [10:0]       roi_x_l,
    output logic [10:0]       roi_x_r,
    output logic [10:0]       roi_y_t,
    output logic [10:0]       roi_y_b,
    output logic [3:0]        roi_idx,
    output logic              roi_last,
    output logic              seq_busy,
    output logic              seq_overrun
);

    localparam logic [3:0] NROW_MAX = 4'(NUM_ROW);
    localparam logic [3:0] NCOL_MAX = 4'(NUM_COL);

    seq_state_e  state_q, state_d;
    logic        flag_q, flag_d, armed_q, armed_d, rise_q, rise_d, overrun_q, overrun_d;
    logic [3:0]  r_q, r_d, c_q, c_d, nr_q, nr_d, nc_q, nc_d;
    logic        valid_q, valid_d, last_q, last_d;
    logic [3:0]  idx_q, idx_d;
    logic [10:0] xl_q, xl_d, xr_q, xr_d, yt_q, yt_d, yb_q, yb_d;
    logic [10:0] xl_c, xr_c, yt_c, yb_c;

    logic              row_start, col_start, row_done, col_done;
    logic [DEPBIT-1:0] row_lead, row_trail, col_lead, col_trail;

    border_pair_reader #(.W(DEPBIT), .IDX_W(4)) u_row_rd (
        .clk     (clk),
        .rst     (rst),
        .start_i (row_start),
        .idx_i   (r_d),
        .data_i  (row_border_data_rd),
        .addr_o  (row_border_addr_rd),
        .lead_o  (row_lead),
        .trail_o (row_trail),
        .done_o  (row_done)
    );

    border_pair_reader #(.W(DEPBIT), .IDX_W(4)) u_col_rd (
        .clk     (clk),
        .rst     (rst),
        .start_i (col_start),
        .idx_i   (c_d),
        .data_i  (col_border_data_rd),
        .addr_o  (col_border_addr_rd),
        .lead_o  (col_lead),
        .trail_o (col_trail),
        .done_o  (col_done)
    );

    always_comb begin
        xl_c = edge_clamp(col_lead, h_total_pexel, 1'b1);
        xr_c = edge_clamp(col_trail, h_total_pexel, 1'b0);
        yt_c = edge_clamp(row_lead, v_total_pexel, 1'b1);
        yb_c = edge_clamp(row_trail, v_total_pexel, 1'b0);
    end

    always_comb begin
        state_d   = state_q;
        r_d       = r_q;
        c_d       = c_q;
        nr_d      = nr_q;
        nc_d      = nc_q;
        valid_d   = valid_q;
        last_d    = last_q;
        idx_d     = idx_q;
        xl_d      = xl_q;
        xr_d      = xr_q;
        yt_d      = yt_q;
        yb_d      = yb_q;
        row_start = 1'b0;
        col_start = 1'b0;
        flag_d    = project_done_flag;
        // Only arm once the flag has been seen low, so a level held through reset is ignored.
        armed_d   = armed_q | ~project_done_flag;
        rise_d    = project_done_flag & ~flag_q & armed_q;
        overrun_d = overrun_q | (rise_q & (state_q != ST_IDLE));

        case (state_q)
            ST_IDLE: begin
                if (rise_q) begin
                    nr_d = (num_row > NROW_MAX) ? NROW_MAX : num_row;
                    nc_d = (num_col > NCOL_MAX) ? NCOL_MAX : num_col;
                    r_d  = '0;
                    c_d  = '0;
                    if (nr_d != 4'd0 && nc_d != 4'd0) begin
                        state_d   = ST_RD_ROW;
                        row_start = 1'b1;
                    end
                end
            end
            ST_RD_ROW: begin
                if (row_done) begin
                    state_d   = ST_RD_COL;
                    col_start = 1'b1;
                end
            end
            ST_RD_COL: begin
                if (col_done) begin
                    state_d = ST_EMIT;
                    valid_d = 1'b1;
                    idx_d   = r_q * nc_q + c_q;
                    last_d  = (r_q == nr_q - 4'd1) && (c_q == nc_q - 4'd1);
                    // Inverted boxes collapse onto their leading edge rather than being dropped.
                    xl_d    = xl_c;
                    xr_d    = (xl_c > xr_c) ? xl_c : xr_c;
                    yt_d    = yt_c;
                    yb_d    = (yt_c > yb_c) ? yt_c : yb_c;
                end
            end
            ST_EMIT: begin
                if (roi_ready) begin
                    valid_d = 1'b0;
                    if (c_q < nc_q - 4'd1) begin
                        c_d       = c_q + 4'd1;
                        state_d   = ST_RD_COL;
                        col_start = 1'b1;
                    end else if (r_q < nr_q - 4'd1) begin
                        r_d       = r_q + 4'd1;
                        c_d       = '0;
                        state_d   = ST_RD_ROW;
                        row_start = 1'b1;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            flag_q    <= 1'b0;
            armed_q   <= 1'b0;
            rise_q    <= 1'b0;
            overrun_q <= 1'b0;
            r_q       <= '0;
            c_q       <= '0;
            nr_q      <= '0;
            nc_q      <= '0;
            valid_q   <= 1'b0;
            last_q    <= 1'b0;
            idx_q     <= '0;
            xl_q      <= '0;
            xr_q      <= '0;
            yt_q      <= '0;
            yb_q      <= '0;
        end else begin
            state_q   <= state_d;
            flag_q    <= flag_d;
            armed_q   <= armed_d;
            rise_q    <= rise_d;
            overrun_q <= overrun_d;
            r_q       <= r_d;
            c_q       <= c_d;
            nr_q      <= nr_d;
            nc_q      <= nc_d;
            valid_q   <= valid_d;
            last_q    <= last_d;
            idx_q     <= idx_d;
            xl_q      <= xl_d;
            xr_q      <= xr_d;
            yt_q      <= yt_d;
            yb_q      <= yb_d;
        end
    end

    assign roi_valid   = valid_q;
    assign roi_last    = last_q;
    assign roi_idx     = idx_q;
    assign roi_x_l     = xl_q;
    assign roi_x_r     = xr_q;
    assign roi_y_t     = yt_q;
    assign roi_y_b     = yb_q;
    assign seq_busy    = (state_q != ST_IDLE);
    assign seq_overrun = overrun_q;

endmodule

// File: tb/tb_digit_roi_sequencer.sv
// Self-checking bench for digit_roi_sequencer: clamp table, hand-written handshake /
// overrun / reset sequences, and randomized frames against a behavioural box model.
module tb_digit_roi_sequencer;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst, flag, roi_valid, roi_ready, roi_last, seq_busy, seq_overrun;
    logic [3:0]  num_row, num_col, roi_idx;
    logic [10:0] h_tot, v_tot, x_l, x_r, y_t, y_b;
    logic [11:0] row_addr, row_data, col_addr, col_data;

    digit_roi_sequencer dut (
        .clk                (clk),
        .rst                (rst),
        .project_done_flag  (flag),
        .num_row            (num_row),
        .num_col            (num_col),
        .h_total_pexel      (h_tot),
        .v_total_pexel      (v_tot),
        .row_border_addr_rd (row_addr),
        .row_border_data_rd (row_data),
        .col_border_addr_rd (col_addr),
        .col_border_data_rd (col_data),
        .roi_valid          (roi_valid),
        .roi_ready          (roi_ready),
        .roi_x_l            (x_l),
        .roi_x_r            (x_r),
        .roi_y_t            (y_t),
        .roi_y_b            (y_b),
        .roi_idx            (roi_idx),
        .roi_last           (roi_last),
        .seq_busy           (seq_busy),
        .seq_overrun        (seq_overrun)
    );

    // Border RAMs with one cycle of read latency.
    logic [11:0] row_mem [32];
    logic [11:0] col_mem [32];
    always @(posedge clk) begin
        row_data <= row_mem[row_addr[4:0]];
        col_data <= col_mem[col_addr[4:0]];
    end

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct packed {
        logic [3:0]  idx;
        logic [10:0] xl, xr, yt, yb;
        logic        last;
    } roi_t;

    typedef struct {
        logic [11:0] cl, ct, rl, rt;
        logic [10:0] h, v, xl, xr, yt, yb;
    } vec_t;

    roi_t got_q[$];
    roi_t exp_q[$];
    int   rise_cyc[$];
    int   acc_cyc[$];
    int   n_cmp = 0;
    int   n_fail = 0;
    bit   busy_seen, valid_seen, rdy_rand;
    int   stall_idx, stall_left, stall_seen, t0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Monitor: samples on the falling edge, records accepted ROIs and checks stability.
    initial begin
        roi_t cur, prev;
        bit   prev_v, prev_r;
        prev_v = 0;
        prev_r = 0;
        prev   = '0;
        forever begin
            @(negedge clk);
            cur = '{idx: roi_idx, xl: x_l, xr: x_r, yt: y_t, yb: y_b, last: roi_last};
            if (rst) begin
                prev_v = 0;
            end else begin
                if (seq_busy) busy_seen = 1;
                if (roi_valid) valid_seen = 1;
                if (roi_valid && !prev_v) rise_cyc.push_back(cyc);
                if (prev_v && !prev_r) begin
                    check("valid_held_under_stall", roi_valid, 1);
                    if (roi_valid) check("fields_held_under_stall", cur, prev);
                end
                if (roi_valid && !roi_ready) stall_seen++;
                if (roi_valid && roi_ready) begin
                    got_q.push_back(cur);
                    acc_cyc.push_back(cyc + 1);
                end
                prev_v = roi_valid;
                prev_r = roi_ready;
                prev   = cur;
            end
        end
    end

    // Ready driver: optional fixed stall on one index, otherwise high or random.
    initial begin
        roi_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            if (stall_left > 0 && roi_valid && roi_idx == 4'(stall_idx)) begin
                roi_ready = 1'b0;
                stall_left--;
            end else begin
                roi_ready = rdy_rand ? 1'($urandom_range(0, 1)) : 1'b1;
            end
        end
    end

    function automatic int lead_clamp(input int val, input int tot);
        return (val >= tot) ? 0 : val;
    endfunction

    function automatic int trail_clamp(input int val, input int tot);
        return (val > tot - 1) ? tot - 1 : val;
    endfunction

    // Expected ROI list straight from the band-pairing rules.
    task automatic build_model();
        int nr, nc, xl, xr, yt, yb;
        exp_q.delete();
        nr = (num_row > 1) ? 1 : int'(num_row);
        nc = (num_col > 4) ? 4 : int'(num_col);
        for (int r = 0; r < nr; r++) begin
            yt = lead_clamp(int'(row_mem[2*r+1]), int'(v_tot));
            yb = trail_clamp(int'(row_mem[2*r+2]), int'(v_tot));
            if (yt > yb) yb = yt;
            for (int c = 0; c < nc; c++) begin
                xl = lead_clamp(int'(col_mem[2*c+1]), int'(h_tot));
                xr = trail_clamp(int'(col_mem[2*c+2]), int'(h_tot));
                if (xl > xr) xr = xl;
                exp_q.push_back('{idx: 4'(r*nc + c), xl: 11'(xl), xr: 11'(xr), yt: 11'(yt),
                                  yb: 11'(yb), last: (r == nr-1) && (c == nc-1)});
            end
        end
    endtask

    task automatic compare_frame();
        check("roi_count", got_q.size(), exp_q.size());
        for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
            check("roi_idx", got_q[i].idx, exp_q[i].idx);
            check("roi_x_l", got_q[i].xl, exp_q[i].xl);
            check("roi_x_r", got_q[i].xr, exp_q[i].xr);
            check("roi_y_t", got_q[i].yt, exp_q[i].yt);
            check("roi_y_b", got_q[i].yb, exp_q[i].yb);
            check("roi_last", got_q[i].last, exp_q[i].last);
        end
    endtask

    // Re-arms and raises the flag, then runs until the sequencer goes idle.
    // toggle_idx >= 0 pulses the flag low/high while that ROI is presented.
    task automatic run_frame(input int budget, input int toggle_idx);
        bit done, toggled;
        got_q.delete();
        rise_cyc.delete();
        acc_cyc.delete();
        busy_seen  = 0;
        valid_seen = 0;
        stall_seen = 0;
        done       = 0;
        toggled    = 0;
        flag = 1'b0;
        tick();
        tick();
        flag = 1'b1;
        t0   = cyc + 1;
        for (int i = 0; i < budget; i++) begin
            tick();
            if (toggle_idx >= 0 && !toggled && roi_valid && roi_idx == 4'(toggle_idx)) begin
                flag = 1'b0;
                tick();
                flag    = 1'b1;
                toggled = 1;
            end
            if (i >= 3 && !seq_busy) begin
                done = 1;
                break;
            end
        end
        check("frame_completes_in_budget", done, 1);
    endtask

    task automatic load_basic();
        for (int i = 0; i < 32; i++) begin
            row_mem[i] = '0;
            col_mem[i] = '0;
        end
        for (int i = 1; i <= 8; i++) col_mem[i] = 12'(10 * i);
        row_mem[1] = 12'd5;
        row_mem[2] = 12'd25;
        h_tot = 11'd640;
        v_tot = 11'd480;
    endtask

    vec_t vecs[8];

    initial begin
        vecs[0] = '{12'd10,   12'd20,   12'd5,    12'd25,   11'd640, 11'd480, 11'd10,  11'd20,  11'd5,   11'd25};
        vecs[1] = '{12'h7FF,  12'd700,  12'h800,  12'd479,  11'd640, 11'd480, 11'd0,   11'd639, 11'd0,   11'd479};
        vecs[2] = '{12'hFFE,  12'd100,  12'd100,  12'd480,  11'd640, 11'd480, 11'd0,   11'd100, 11'd100, 11'd479};
        vecs[3] = '{12'd639,  12'd639,  12'd479,  12'd1000, 11'd640, 11'd480, 11'd639, 11'd639, 11'd479, 11'd479};
        vecs[4] = '{12'd640,  12'd639,  12'd480,  12'd0,    11'd640, 11'd480, 11'd0,   11'd639, 11'd0,   11'd0};
        vecs[5] = '{12'd300,  12'd200,  12'd400,  12'd100,  11'd640, 11'd480, 11'd300, 11'd300, 11'd400, 11'd400};
        vecs[6] = '{12'd700,  12'd50,   12'd10,   12'd9,    11'd640, 11'd480, 11'd0,   11'd50,  11'd10,  11'd10};
        vecs[7] = '{12'd500,  12'd2000, 12'd0,    12'd0,    11'd100, 11'd50,  11'd0,   11'd99,  11'd0,   11'd0};

        rst        = 1'b1;
        flag       = 1'b0;
        num_row    = '0;
        num_col    = '0;
        rdy_rand   = 0;
        stall_idx  = 0;
        stall_left = 0;
        load_basic();
        repeat (3) tick();

        check("rst_roi_valid", roi_valid, 0);
        check("rst_roi_last", roi_last, 0);
        check("rst_roi_idx", roi_idx, 0);
        check("rst_roi_edges", {x_l, x_r, y_t, y_b}, 0);
        check("rst_row_addr", row_addr, 0);
        check("rst_col_addr", col_addr, 0);
        check("rst_seq_busy", seq_busy, 0);
        check("rst_seq_overrun", seq_overrun, 0);
        rst = 1'b0;
        repeat (2) tick();

        // Basic 1x4 frame with ready tied high.
        num_row = 4'd1;
        num_col = 4'd4;
        run_frame(200, -1);
        build_model();
        compare_frame();
        if (rise_cyc.size() > 0) check("first_valid_latency", rise_cyc[0] - t0, 7);
        for (int i = 1; i < rise_cyc.size() && i <= acc_cyc.size(); i++)
            check("accept_to_next_valid", rise_cyc[i] - acc_cyc[i-1], 3);
        check("no_overrun_basic", seq_overrun, 0);

        // Clamp table, one 1x1 frame per entry.
        for (int i = 0; i < 8; i++) begin
            col_mem[1] = vecs[i].cl;
            col_mem[2] = vecs[i].ct;
            row_mem[1] = vecs[i].rl;
            row_mem[2] = vecs[i].rt;
            h_tot      = vecs[i].h;
            v_tot      = vecs[i].v;
            num_row    = 4'd1;
            num_col    = 4'd1;
            run_frame(100, -1);
            check("tbl_count", got_q.size(), 1);
            if (got_q.size() > 0) begin
                check("tbl_x_l", got_q[0].xl, vecs[i].xl);
                check("tbl_x_r", got_q[0].xr, vecs[i].xr);
                check("tbl_y_t", got_q[0].yt, vecs[i].yt);
                check("tbl_y_b", got_q[0].yb, vecs[i].yb);
                check("tbl_last", got_q[0].last, 1);
                check("tbl_idx", got_q[0].idx, 0);
            end
        end

        // Backpressure: ROI 1 held for 10 cycles.
        load_basic();
        num_row    = 4'd1;
        num_col    = 4'd4;
        stall_idx  = 1;
        stall_left = 10;
        run_frame(200, -1);
        build_model();
        compare_frame();
        check("stall_cycles", stall_seen, 10);
        stall_left = 0;

        // Column count above the maximum is clamped.
        num_col = 4'd9;
        run_frame(200, -1);
        build_model();
        check("clamped_col_count", got_q.size(), 4);
        compare_frame();

        // Zero row bands: nothing happens.
        num_row = 4'd0;
        num_col = 4'd4;
        run_frame(50, -1);
        check("zero_rows_no_valid", valid_seen, 0);
        check("zero_rows_no_busy", busy_seen, 0);

        // Re-trigger while busy during ROI 2.
        num_row = 4'd1;
        run_frame(200, 2);
        build_model();
        compare_frame();
        check("overrun_set", seq_overrun, 1);

        // Reset while a ROI is being presented.
        stall_idx  = 0;
        stall_left = 1000;
        flag = 1'b0;
        tick();
        tick();
        flag = 1'b1;
        begin
            bit seen;
            seen = 0;
            for (int i = 0; i < 30 && !seen; i++) begin
                tick();
                seen = roi_valid;
            end
            check("valid_before_reset", seen, 1);
        end
        rst        = 1'b1;
        stall_left = 0;
        tick();
        check("reset_drops_valid", roi_valid, 0);
        check("reset_drops_busy", seq_busy, 0);
        check("reset_clears_overrun", seq_overrun, 0);
        rst = 1'b0;
        valid_seen = 0;
        busy_seen  = 0;
        repeat (30) tick();
        check("held_flag_no_valid", valid_seen, 0);
        check("held_flag_no_busy", busy_seen, 0);

        // Randomized frames with random ready.
        rdy_rand = 1;
        for (int it = 0; it < 25; it++) begin
            for (int i = 0; i < 32; i++) begin
                row_mem[i] = ($urandom_range(0, 3) == 0) ? 12'($urandom) : 12'($urandom_range(0, 2047));
                col_mem[i] = ($urandom_range(0, 3) == 0) ? 12'($urandom) : 12'($urandom_range(0, 2047));
            end
            num_row = 4'($urandom_range(0, 3));
            num_col = 4'($urandom_range(0, 9));
            h_tot   = 11'($urandom_range(1, 2047));
            v_tot   = 11'($urandom_range(1, 2047));
            run_frame(600, -1);
            build_model();
            compare_frame();
        end
        rdy_rand = 0;
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/digit_roi_sequencer.md
# digit_roi_sequencer

Sequencer for the projection border RAMs. After the projection stage raises its done flag, this block walks the row-border and column-border RAM read ports. It pairs each row band with each column band and emits one clamped bounding box (ROI) per digit over a valid/ready handshake to the downstream feature-extraction stage. It is the sole reader of both border RAMs and sits between projection and the digit recogniser.

## Interface
- NUM_ROW, 1, maximum row bands supported; counts above this are clamped.
- NUM_COL, 4, maximum column bands supported; counts above this are clamped.
- DEPBIT, 12, border RAM address and data width.

Ports:
- clk  in  1  single clock, same domain as projection.
- rst  in  1  reset; synchronous, active-high.
- project_done_flag  in  1  projection complete; a level that stays high through the process phase.
- num_row  in  4  row bands found.
- num_col  in  4  column bands found.
- h_total_pexel  in  11  active width, used for clamping.
- v_total_pexel  in  11  active height, used for clamping.
- row_border_addr_rd  out  DEPBIT  row border RAM read address.
- row_border_data_rd  in  DEPBIT  row border RAM read data; 1-cycle latency.
- col_border_addr_rd  out  DEPBIT  column border RAM read address.
- col_border_data_rd  in  DEPBIT  column border RAM read data; 1-cycle latency.
- roi_valid  out  1  ROI available.
- roi_ready  in  1  downstream accepts the ROI.
- roi_x_l, roi_x_r, roi_y_t, roi_y_b  out  11 each  box edges, inclusive.
- roi_idx  out  4  linear digit index, r*num_col_eff + c.
- roi_last  out  1  marks the final ROI of the frame.
- seq_busy  out  1  sequencer is active.
- seq_overrun  out  1  sticky; a trigger arrived while busy.

## Operation
- Trigger: rising edge of project_done_flag, detected with a registered copy.
- Latch at trigger: num_row_eff = min(num_row, NUM_ROW), num_col_eff = min(num_col, NUM_COL).
- Border RAM layout (fixed by the writer): band k has its leading edge at address 2k+1 and its trailing edge at 2k+2. Address 0 is unused.
- States:
  - IDLE: on trigger, if either effective count is 0, go to IDLE and pulse nothing; otherwise go to RD_ROW.
  - RD_ROW: read rows 2r+1 and 2r+2, then go to RD_COL.
  - RD_COL: read columns 2c+1 and 2c+2, then go to EMIT.
  - EMIT: hold roi_valid until roi_ready.
    - On accept, if c < num_col_eff-1: c++ and go to RD_COL.
    - Else, if r < num_row_eff-1: r++, c = 0, and go to RD_ROW.
    - Else go to IDLE.
- Row loop is outer, column loop is inner. Row edges are read once per row and reused for every column in that row.
- Clamping:
  - Leading-edge data has 2 subtracted upstream, so it can wrap. Any value ≥ h_total_pexel (x) or ≥ v_total_pexel (y) on a leading edge is forced to 0.
  - A trailing edge > total-1 is forced to total-1.
  - If, after clamping, left > right or top > bottom, the ROI is still emitted with both edges set to the leading value (a degenerate box). It is not dropped.
- roi_last = (r == num_row_eff-1) && (c == num_col_eff-1).
- A trigger while seq_busy is ignored and sets seq_overrun. seq_overrun clears only on rst.

## Timing
- Reset values:
  - roi_valid = 0, roi_last = 0, roi_idx = 0.
  - All roi edges = 0.
  - Both read addresses = 0.
  - seq_busy = 0, seq_overrun = 0.
  - State = IDLE, and the edge-detect register = 0. A flag that is already high at reset release does not trigger.
- Read sequencing per pair:
  - Address 2k+1 is driven in cycle t and 2k+2 in cycle t+1.
  - Data is captured at t+1 and t+2.
  - A pair costs 3 cycles.
- Latency from trigger to first roi_valid: 7 cycles.
  - Detect 1, row pair 3, column pair 3.
  - roi_valid rises in the cycle after the last column capture.
- Between ROIs in the same row: 3 cycles from accept to the next roi_valid. On a row change: 6 cycles.
- Handshake:
  - All ROI outputs are registered and stable while roi_valid=1 && roi_ready=0.
  - A transfer occurs on a cycle where both are high.
  - roi_valid drops in the next cycle unless the next ROI is ready. That cannot happen here, so there is at least 1 idle cycle between ROIs.
- seq_busy is high from the cycle after the trigger through the cycle in which the last ROI is accepted.
- Reset asserted mid-frame aborts immediately: outputs return to reset values on the next edge, and no partial ROI is emitted.

## Structure
- Shared package (digit_pkg) holds:
  - State encoding localparams ST_IDLE, ST_RD_ROW, ST_RD_COL, ST_EMIT.
  - The border address mapping constants: LEAD_OFS=1, TRAIL_OFS=2.
  - An edge clamp function taking (value, total) and returning the clamped 11-bit value.
- One natural sub-module: border_pair_reader. It issues two consecutive addresses and returns the captured lead/trail pair with a done pulse. It is instantiated twice, once for rows and once for columns.

## Test plan
- num_row=1, num_col=4, column borders {10,20,30,40,50,60,70,80}, row border {5,25}, ready tied high:
  - 4 ROIs, idx 0..3, x = (10,20),(30,40),(50,60),(70,80), y = (5,25).
  - roi_last only on idx 3.
  - First valid 7 cycles after the trigger.
- Backpressure: hold roi_ready low for 10 cycles on ROI 1. Outputs stay constant, no ROI is skipped, and idx remains 1 until accepted.
- Clamp: leading column value 0x7FF with h_total=640 gives x_l=0. Trailing column value 700 gives x_r=639.
- Counts: num_col=9 with NUM_COL=4 gives exactly 4 ROIs. num_row=0 gives no roi_valid and seq_busy stays low.
- Overrun: toggle project_done_flag low then high during ROI 2. seq_overrun=1, and the current sequence completes unchanged.
- Reset: assert rst while roi_valid=1. Next cycle roi_valid=0 and seq_busy=0. A flag held high after release produces no ROIs.
